// File: rtl/pc_adder_pkg.sv
// pc_adder_pkg
// Shared definitions for the program-counter incrementer slice.
//   PC_WIDTH     : native PC width of the datapath.
//   PC_INCREMENT : bytes per instruction, the amount added each fetch.
//   pc_t         : PC-sized vector type for surrounding datapath code.
package pc_adder_pkg;

    localparam int          PC_WIDTH     = 32;
    localparam int unsigned PC_INCREMENT = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/cla_adder32.sv
// cla_adder32
// Carry-lookahead adder built from 4-bit groups. Each group produces its
// internal carries as flat lookahead terms plus a group propagate/generate
// pair; the group pairs form the inter-group carry chain.
// Ports:
//   a, b : addends (WIDTH bits, unsigned)
//   cin  : carry in
//   sum  : (a + b + cin) mod 2^WIDTH
//   cout : carry out of bit WIDTH-1
module cla_adder32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Operands are padded to a whole number of 4-bit groups.
    localparam int GROUPS = (WIDTH + 3) / 4;
    localparam int NP     = GROUPS * 4;

    logic [NP-1:0]     ax;
    logic [NP-1:0]     bx;
    logic [NP-1:0]     p;
    logic [NP-1:0]     g;
    logic [NP:0]       c;
    logic [GROUPS-1:0] gp;
    logic [GROUPS-1:0] gg;

    assign ax   = NP'(a);
    assign bx   = NP'(b);
    assign p    = ax ^ bx;
    assign g    = ax & bx;
    assign c[0] = cin;

    for (genvar grp = 0; grp < GROUPS; grp++) begin : g_group
        localparam int B = 4 * grp;

        assign gp[grp] = &p[B+3:B];
        assign gg[grp] = g[B+3]
                       | (p[B+3] & g[B+2])
                       | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);

        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = gg[grp] | (gp[grp] & c[B]);
    end

    assign sum  = p[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/pc_adder.sv
// pc_adder
// Program-counter incrementer: PCResult + INCREMENT for the next-PC mux,
// with a registered copy, carry-out (wrap) flags and optional alignment
// checking.
// Optional feature macro: PC_ADDER_ALIGN_CHECK_EN enables Misaligned and
// MisalignSticky; without it both are tied low and no alignment flop exists.
// Ports:
//   Clk            : rising-edge clock for all registered outputs
//   Reset          : asynchronous active-high reset of registered outputs
//   PCResult       : current PC
//   PCAddResult    : PCResult + INCREMENT (combinational)
//   Wrap           : carry out of the addition (combinational)
//   PCAddResultQ   : PCAddResult registered
//   WrapQ          : Wrap registered
//   Misaligned     : PCResult[1:0] != 0 (combinational)
//   MisalignSticky : set once a misaligned PC is registered, cleared by Reset
module pc_adder
    import pc_adder_pkg::*;
#(
    parameter int          WIDTH     = PC_WIDTH,
    parameter int unsigned INCREMENT = PC_INCREMENT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCAddResult,
    output logic             Wrap,
    output logic [WIDTH-1:0] PCAddResultQ,
    output logic             WrapQ,
    output logic             Misaligned,
    output logic             MisalignSticky
);

    localparam logic [WIDTH-1:0] INC_VEC = WIDTH'(INCREMENT);

    logic [WIDTH-1:0] pc_sum_p1;
    logic             wrap_p1;

    // Stage p0: combinational increment
    cla_adder32 #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a    (PCResult),
        .b    (INC_VEC),
        .cin  (1'b0),
        .sum  (PCAddResult),
        .cout (Wrap)
    );

    // Stage p1: registered copy of the increment
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_sum_p1 <= '0;
            wrap_p1   <= 1'b0;
        end else begin
            pc_sum_p1 <= PCAddResult;
            wrap_p1   <= Wrap;
        end
    end

    assign PCAddResultQ = pc_sum_p1;
    assign WrapQ        = wrap_p1;

`ifdef PC_ADDER_ALIGN_CHECK_EN
    logic sticky_p1;

    assign Misaligned = |PCResult[1:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sticky_p1 <= 1'b0;
        end else if (Misaligned) begin
            sticky_p1 <= 1'b1;
        end
    end

    assign MisalignSticky = sticky_p1;
`else
    assign Misaligned     = 1'b0;
    assign MisalignSticky = 1'b0;
`endif

endmodule

// File: tb/tb_pc_adder.sv
module tb_pc_adder;

`ifdef PC_ADDER_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        Wrap;
    logic [31:0] PCAddResultQ;
    logic        WrapQ;
    logic        Misaligned;
    logic        MisalignSticky;

    int checks = 0;
    int errors = 0;

    // Reference state for registered outputs
    logic [31:0] m_q;
    logic        m_wq;
    logic        m_sticky;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] sum;
        logic        wrap;
    } vec_t;

    vec_t tbl[10];

    pc_adder #(
        .WIDTH     (32),
        .INCREMENT (4)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PCResult       (PCResult),
        .PCAddResult    (PCAddResult),
        .Wrap           (Wrap),
        .PCAddResultQ   (PCAddResultQ),
        .WrapQ          (WrapQ),
        .Misaligned     (Misaligned),
        .MisalignSticky (MisalignSticky)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 33-bit arithmetic on the PC
    function automatic logic [32:0] ref_add(input logic [31:0] pc);
        return {1'b0, pc} + 33'd4;
    endfunction

    function automatic logic ref_mis(input logic [31:0] pc);
        return ALIGN_EN && (pc % 4 != 0);
    endfunction

    task automatic check_comb(input string tag);
        logic [32:0] r;
        r = ref_add(PCResult);
        chk({tag, ".sum"},  PCAddResult, r[31:0]);
        chk({tag, ".wrap"}, Wrap, r[32]);
        chk({tag, ".mis"},  Misaligned, ref_mis(PCResult));
    endtask

    // Advance one rising edge, update the model, sample 1 time unit later
    task automatic clock_and_check(input string tag);
        logic [32:0] r;
        r = ref_add(PCResult);
        @(posedge Clk);
        if (!Reset) begin
            m_q  = r[31:0];
            m_wq = r[32];
            if (ref_mis(PCResult)) m_sticky = 1'b1;
        end
        #1;
        chk({tag, ".q"},      PCAddResultQ, m_q);
        chk({tag, ".wq"},     WrapQ, m_wq);
        chk({tag, ".sticky"}, MisalignSticky, m_sticky);
    endtask

    task automatic drive(input logic [31:0] pc);
        @(negedge Clk);
        PCResult = pc;
        #1;
    endtask

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0};
        tbl[1] = '{32'h0000_0001, 32'h0000_0005, 1'b0};
        tbl[2] = '{32'h0000_0007, 32'h0000_000B, 1'b0};
        tbl[3] = '{32'h0000_0082, 32'h0000_0086, 1'b0};
        tbl[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0003, 1'b1};
        tbl[6] = '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0};
        tbl[7] = '{32'h0040_0000, 32'h0040_0004, 1'b0};
        tbl[8] = '{32'h7FFF_FFFC, 32'h8000_0000, 1'b0};
        tbl[9] = '{32'h0FFF_FFFE, 32'h1000_0002, 1'b0};

        Reset    = 1'b1;
        PCResult = 32'h0000_0010;
        m_q      = '0;
        m_wq     = 1'b0;
        m_sticky = 1'b0;

        // Reset state, with a clock edge occurring during reset
        #2;
        chk("rst.q", PCAddResultQ, 32'h0);
        chk("rst.wq", WrapQ, 1'b0);
        chk("rst.sticky", MisalignSticky, 1'b0);
        chk("rst.comb", PCAddResult, 32'h0000_0014);
        @(posedge Clk);
        #1;
        chk("rst.hold", PCAddResultQ, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        // Table vectors with hand-computed expectations
        foreach (tbl[i]) begin
            drive(tbl[i].pc);
            chk($sformatf("tbl%0d.sum", i),  PCAddResult, tbl[i].sum);
            chk($sformatf("tbl%0d.wrap", i), Wrap, tbl[i].wrap);
            chk($sformatf("tbl%0d.mis", i),  Misaligned, ALIGN_EN && (tbl[i].pc[1:0] != 2'b00));
            clock_and_check($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.qsum", i), PCAddResultQ, tbl[i].sum);
            chk($sformatf("tbl%0d.qwrap", i), WrapQ, tbl[i].wrap);
        end

        // Low-range sweep, combinational only
        for (int v = 0; v <= 130; v++) begin
            drive(32'(v));
            chk($sformatf("sweep%0d", v), PCAddResult, 32'(v + 4));
            chk($sformatf("sweep%0d.wrap", v), Wrap, 1'b0);
        end

        // Asynchronous reset mid-stream
        Reset = 1'b1;
        #1;
        m_q = '0; m_wq = 1'b0; m_sticky = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        drive(32'h0000_0000);
        clock_and_check("pre");
        drive(32'h0040_0000);
        chk("lat.notyet", PCAddResultQ, 32'h0000_0004);
        clock_and_check("lat");
        chk("lat.q", PCAddResultQ, 32'h0040_0004);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst.q", PCAddResultQ, 32'h0);
        chk("arst.wq", WrapQ, 1'b0);
        chk("arst.sticky", MisalignSticky, 1'b0);
        chk("arst.comb", PCAddResult, 32'h0040_0004);
        m_q = '0; m_wq = 1'b0; m_sticky = 1'b0;
        @(posedge Clk);
        #1;
        chk("arst.hold", PCAddResultQ, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        clock_and_check("arst.release");
        chk("arst.release.q", PCAddResultQ, 32'h0040_0004);

        // Wrap registration
        drive(32'hFFFF_FFFC);
        clock_and_check("wrapq");
        chk("wrapq.flag", WrapQ, 1'b1);

        // Alignment sequence
        drive(32'h0000_0002);
        chk("al2.mis", Misaligned, ALIGN_EN);
        clock_and_check("al2");
        chk("al2.sticky", MisalignSticky, ALIGN_EN);
        drive(32'h0000_0008);
        chk("al8.mis", Misaligned, 1'b0);
        clock_and_check("al8");
        chk("al8.sticky", MisalignSticky, ALIGN_EN);
        drive(32'h0000_0003);
        chk("al3.sum", PCAddResult, 32'h0000_0007);
        chk("al3.mis", Misaligned, ALIGN_EN);
        clock_and_check("al3");

        // Randomized stimulus, with occasional resets and top-of-range values
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            case ($urandom_range(0, 3))
                0:       pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       pc = {$urandom, 2'b00} >> 2 << 2;
                default: pc = $urandom;
            endcase
            drive(pc);
            check_comb($sformatf("rnd%0d", n));
            if ($urandom_range(0, 49) == 0) begin
                Reset = 1'b1;
                #1;
                m_q = '0; m_wq = 1'b0; m_sticky = 1'b0;
                chk($sformatf("rnd%0d.rq", n), PCAddResultQ, m_q);
                chk($sformatf("rnd%0d.rs", n), MisalignSticky, m_sticky);
                @(negedge Clk);
                Reset = 1'b0;
                #1;
            end
            clock_and_check($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
